// File: rtl/csr_timer_bank_if.sv
// ============================================================================
// Module      : csr_timer_bank_if
// Description : Shared CSR read/write port bundle used by csr_timer_bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface csr_timer_bank_if;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_rvalue;
  logic        csr_hit;

  modport master (
    output csr_num, csr_we, csr_wmask, csr_wvalue,
    input  csr_rvalue, csr_hit
  );

  modport slave (
    input  csr_num, csr_we, csr_wmask, csr_wvalue,
    output csr_rvalue, csr_hit
  );
endinterface

`default_nettype wire

// File: rtl/csr_timer_bank.sv
// ============================================================================
// Module      : csr_timer_bank
// Description : NUM_TIMERS independent TCFG/TVAL/TICLR timer channels with
//               registered interrupt-pending lines; optional 64-bit stable
//               counter built when CSR_STABLE_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_timer_bank #(
  parameter int          NUM_TIMERS = 2,
  parameter int          TIMER_W    = 32,
  parameter logic [13:0] CSR_BASE   = 14'h0041
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  csr_timer_bank_if.slave            csr,
  output logic [NUM_TIMERS-1:0]      timer_int,
  output logic [63:0]                stable_cnt
);

  localparam logic [13:0] SPAN    = 14'(4 * NUM_TIMERS);
  localparam logic [1:0]  R_TCFG  = 2'd0;
  localparam logic [1:0]  R_TVAL  = 2'd1;
  localparam logic [1:0]  R_TICLR = 2'd3;

  logic [13:0] offset;
  logic        in_range;
  logic [1:0]  reg_sel;
  logic [31:0] tcfg_rd [NUM_TIMERS];
  logic [31:0] tval_rd [NUM_TIMERS];

  // Wrap-around of the subtraction puts numbers below CSR_BASE out of range.
  assign offset   = csr.csr_num - CSR_BASE;
  assign in_range = (offset < SPAN);
  assign reg_sel  = offset[1:0];
  assign csr.csr_hit = in_range && (reg_sel != 2'd2);

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_chan
    logic                 en;
    logic                 periodic;
    logic [TIMER_W-3:0]   initv;
    logic [TIMER_W-1:0]   cnt;
    logic                 pending;
    logic                 chan_match;
    logic                 tcfg_we;
    logic                 ticlr_we;
    logic [TIMER_W-1:0]   cfg_old;
    logic [TIMER_W-1:0]   cfg_new;

    assign chan_match = in_range && (offset[3:2] == 2'(i));
    assign tcfg_we    = csr.csr_we && chan_match && (reg_sel == R_TCFG);
    assign ticlr_we   = csr.csr_we && chan_match && (reg_sel == R_TICLR)
                        && csr.csr_wmask[0] && csr.csr_wvalue[0];

    assign cfg_old = {initv, periodic, en};
    assign cfg_new = (csr.csr_wmask[TIMER_W-1:0] & csr.csr_wvalue[TIMER_W-1:0])
                   | (~csr.csr_wmask[TIMER_W-1:0] & cfg_old);

    always_ff @(posedge clk) begin
      if (reset) begin
        en       <= 1'b0;
        periodic <= 1'b0;
        initv    <= '0;
        cnt      <= '1;
        pending  <= 1'b0;
      end else begin
        if (tcfg_we) begin
          en       <= cfg_new[0];
          periodic <= cfg_new[1];
          initv    <= cfg_new[TIMER_W-1:2];
        end

        // A config write always owns the counter: load when enabling, hold otherwise.
        if (tcfg_we) begin
          if (cfg_new[0]) begin
            cnt <= {cfg_new[TIMER_W-1:2], 2'b00};
          end
        end else if (en && (cnt != '1)) begin
          if ((cnt == '0) && periodic) begin
            cnt <= {initv, 2'b00};
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        if (en && (cnt == '0)) begin
          pending <= 1'b1;
        end else if (ticlr_we) begin
          pending <= 1'b0;
        end
      end
    end

    assign tcfg_rd[i]   = 32'(cfg_old);
    assign tval_rd[i]   = 32'(cnt);
    assign timer_int[i] = pending;
  end

  always_comb begin
    csr.csr_rvalue = '0;
    for (int j = 0; j < NUM_TIMERS; j++) begin
      if (in_range && (offset[3:2] == 2'(j))) begin
        case (reg_sel)
          R_TCFG:  csr.csr_rvalue = tcfg_rd[j];
          R_TVAL:  csr.csr_rvalue = tval_rd[j];
          default: csr.csr_rvalue = '0;
        endcase
      end
    end
  end

`ifdef CSR_STABLE_CNT_EN
  logic [63:0] stable_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= '0;
    end else begin
      stable_q <= stable_q + 64'd1;
    end
  end

  assign stable_cnt = stable_q;
`else
  assign stable_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_csr_timer_bank.sv
// ============================================================================
// Module      : tb_csr_timer_bank
// Description : Self-checking bench for csr_timer_bank (32-bit and 16-bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_timer_bank;

  localparam logic [13:0] BASE = 14'h0041;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  csr_timer_bank_if bus();
  csr_timer_bank_if nbus();

  logic [1:0]  timer_int;
  logic [0:0]  ntimer_int;
  logic [63:0] stable_cnt;
  logic [63:0] nstable_cnt;

  csr_timer_bank #(.NUM_TIMERS(2), .TIMER_W(32), .CSR_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .csr(bus), .timer_int(timer_int), .stable_cnt(stable_cnt)
  );

  csr_timer_bank #(.NUM_TIMERS(1), .TIMER_W(16), .CSR_BASE(BASE)) dut_n (
    .clk(clk), .reset(reset), .csr(nbus), .timer_int(ntimer_int), .stable_cnt(nstable_cnt)
  );

  typedef struct {
    logic [31:0] tval;
    logic        intr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [13:0] addr(input int ch, input int off);
    return BASE + 14'(4 * ch + off);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    bus.csr_num    = num;
    bus.csr_wmask  = mask;
    bus.csr_wvalue = val;
    bus.csr_we     = 1'b1;
    step();
    bus.csr_we     = 1'b0;
  endtask

  task automatic rd(input logic [13:0] num, output logic [31:0] v);
    bus.csr_num = num;
    bus.csr_we  = 1'b0;
    #1;
    v = bus.csr_rvalue;
  endtask

  task automatic nwr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    nbus.csr_num    = num;
    nbus.csr_wmask  = mask;
    nbus.csr_wvalue = val;
    nbus.csr_we     = 1'b1;
    step();
    nbus.csr_we     = 1'b0;
  endtask

  task automatic nrd(input logic [13:0] num, output logic [31:0] v);
    nbus.csr_num = num;
    nbus.csr_we  = 1'b0;
    #1;
    v = nbus.csr_rvalue;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    n_checks++;
    if (timer_int !== 2'b00) begin n_fail++; $display("FAIL reset_int got %b expected 00", timer_int); end
    rd(addr(0, 1), v);
    n_checks++;
    if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_tval0 got %h expected ffffffff", v); end
    rd(addr(1, 1), v);
    n_checks++;
    if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_tval1 got %h expected ffffffff", v); end
    rd(addr(1, 0), v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_tcfg1 got %h expected 0", v); end
    rd(addr(0, 2), v);
    n_checks++;
    if (bus.csr_hit !== 1'b0 || v !== 32'h0) begin
      n_fail++; $display("FAIL hole_hit got hit=%b data=%h expected hit=0 data=0", bus.csr_hit, v);
    end
    rd(addr(1, 3), v);
    n_checks++;
    if (bus.csr_hit !== 1'b1 || v !== 32'h0) begin
      n_fail++; $display("FAIL ticlr_hit got hit=%b data=%h expected hit=1 data=0", bus.csr_hit, v);
    end
    rd(BASE - 14'd1, v);
    n_checks++;
    if (bus.csr_hit !== 1'b0) begin n_fail++; $display("FAIL below_base_hit got %b expected 0", bus.csr_hit); end
    rd(addr(2, 0), v);
    n_checks++;
    if (bus.csr_hit !== 1'b0) begin n_fail++; $display("FAIL above_span_hit got %b expected 0", bus.csr_hit); end
    repeat (4) step();
    n_checks++;
`ifdef CSR_STABLE_CNT_EN
    if (stable_cnt !== 64'd4) begin n_fail++; $display("FAIL stable_cnt got %0d expected 4", stable_cnt); end
`else
    if (stable_cnt !== 64'd0) begin n_fail++; $display("FAIL stable_cnt got %0d expected 0", stable_cnt); end
`endif
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    int k;
    wr(addr(0, 0), 32'hFFFF_FFFF, 32'h11);
    for (int j = 16; j >= 0; j--) sb.push_back('{tval: 32'(j), intr: 1'b0});
    repeat (3) sb.push_back('{tval: 32'hFFFF_FFFF, intr: 1'b1});
    k = 0;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      rd(addr(0, 1), v);
      n_checks++;
      if (v !== e.tval || timer_int[0] !== e.intr) begin
        n_fail++;
        $display("FAIL oneshot step %0d got tval=%h int=%b expected tval=%h int=%b", k, v, timer_int[0], e.tval, e.intr);
      end
      k++;
      step();
    end
    wr(addr(0, 3), 32'h1, 32'h1);
    n_checks++;
    if (timer_int[0] !== 1'b0) begin n_fail++; $display("FAIL oneshot_clear got %b expected 0", timer_int[0]); end
  endtask

  task automatic test_periodic();
    logic [31:0] v;
    logic [31:0] v0;
    wr(addr(1, 0), 32'hFFFF_FFFF, 32'h0B);
    for (int j = 0; j < 18; j++)
      sb.push_back('{tval: (j < 9) ? 32'(8 - j) : 32'(17 - j), intr: (j >= 9)});
    for (int j = 0; sb.size() > 0; j++) begin
      exp_t e;
      e = sb.pop_front();
      rd(addr(1, 1), v);
      rd(addr(0, 1), v0);
      n_checks++;
      if (v !== e.tval || timer_int[1] !== e.intr || timer_int[0] !== 1'b0 || v0 !== 32'hFFFF_FFFF) begin
        n_fail++;
        $display("FAIL periodic step %0d got tval1=%h int=%b tval0=%h expected tval1=%h int=%b%b tval0=ffffffff",
                 j, v, timer_int, v0, e.tval, e.intr, 1'b0);
      end
      step();
    end
  endtask

  task automatic test_clear_race();
    logic [31:0] v;
    logic found;
    found = 1'b0;
    for (int j = 0; j < 12 && !found; j++) begin
      rd(addr(1, 1), v);
      if (v == 32'h0) found = 1'b1;
      else step();
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL race_wait got timeout expected tval1=0"); end
    wr(addr(1, 3), 32'h1, 32'h1);
    rd(addr(1, 1), v);
    n_checks++;
    if (timer_int[1] !== 1'b1 || v !== 32'd8) begin
      n_fail++; $display("FAIL race_set_wins got int=%b tval=%h expected int=1 tval=8", timer_int[1], v);
    end
    wr(addr(1, 3), 32'h1, 32'h1);
    n_checks++;
    if (timer_int[1] !== 1'b0) begin n_fail++; $display("FAIL clear got %b expected 0", timer_int[1]); end
    wr(addr(1, 0), 32'hFFFF_FFFF, 32'h0);
  endtask

  task automatic test_masked();
    logic [31:0] v;
    wr(addr(0, 0), 32'hFFFF_FFFF, 32'h13);
    rd(addr(0, 0), v);
    n_checks++;
    if (v !== 32'h13) begin n_fail++; $display("FAIL mask_tcfg_full got %h expected 13", v); end
    repeat (3) step();
    wr(addr(0, 0), 32'h1, 32'h0);
    rd(addr(0, 0), v);
    n_checks++;
    if (v !== 32'h12) begin n_fail++; $display("FAIL mask_tcfg_bit0 got %h expected 12", v); end
    repeat (2) step();
    rd(addr(0, 1), v);
    n_checks++;
    if (v !== 32'd13) begin n_fail++; $display("FAIL mask_freeze got %h expected d", v); end
    wr(addr(0, 0), 32'h0, 32'hFFFF_FFFF);
    wr(addr(0, 1), 32'hFFFF_FFFF, 32'h0);
    rd(addr(0, 0), v);
    n_checks++;
    if (v !== 32'h12) begin n_fail++; $display("FAIL mask_zero_tcfg got %h expected 12", v); end
    rd(addr(0, 1), v);
    n_checks++;
    if (v !== 32'd13) begin n_fail++; $display("FAIL tval_readonly got %h expected d", v); end
  endtask

  task automatic test_narrow();
    logic [31:0] v;
    nwr(addr(0, 0), 32'hFFFF_FFFF, 32'hFFFF_0005);
    nrd(addr(0, 0), v);
    n_checks++;
    if (v !== 32'h0005) begin n_fail++; $display("FAIL narrow_tcfg got %h expected 5", v); end
    for (int j = 4; j >= 0; j--) sb.push_back('{tval: 32'(j), intr: 1'b0});
    repeat (2) sb.push_back('{tval: 32'h0000_FFFF, intr: 1'b1});
    for (int j = 0; sb.size() > 0; j++) begin
      exp_t e;
      e = sb.pop_front();
      nrd(addr(0, 1), v);
      n_checks++;
      if (v !== e.tval || ntimer_int[0] !== e.intr) begin
        n_fail++;
        $display("FAIL narrow step %0d got tval=%h int=%b expected tval=%h int=%b", j, v, ntimer_int[0], e.tval, e.intr);
      end
      step();
    end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] v;
    wr(addr(0, 0), 32'hFFFF_FFFF, 32'h07);
    repeat (7) step();
    n_checks++;
    if (timer_int[0] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_int got %b expected 1", timer_int[0]); end
    wr(addr(1, 0), 32'hFFFF_FFFF, 32'h41);
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (timer_int !== 2'b00 || ntimer_int !== 1'b0 || stable_cnt !== 64'd0) begin
      n_fail++;
      $display("FAIL midreset_out got int=%b nint=%b stable=%0d expected 00 0 0", timer_int, ntimer_int, stable_cnt);
    end
    rd(addr(0, 1), v);
    n_checks++;
    if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL midreset_tval0 got %h expected ffffffff", v); end
    rd(addr(0, 0), v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL midreset_tcfg0 got %h expected 0", v); end
    repeat (5) step();
    rd(addr(1, 1), v);
    n_checks++;
    if (v !== 32'hFFFF_FFFF || timer_int !== 2'b00) begin
      n_fail++; $display("FAIL midreset_hold got tval1=%h int=%b expected ffffffff 00", v, timer_int);
    end
    n_checks++;
`ifdef CSR_STABLE_CNT_EN
    if (stable_cnt !== 64'd5) begin n_fail++; $display("FAIL midreset_stable got %0d expected 5", stable_cnt); end
`else
    if (stable_cnt !== 64'd0) begin n_fail++; $display("FAIL midreset_stable got %0d expected 0", stable_cnt); end
`endif
  endtask

  initial begin
    bus.csr_num = '0;  bus.csr_we = 1'b0;  bus.csr_wmask = '0;  bus.csr_wvalue = '0;
    nbus.csr_num = '0; nbus.csr_we = 1'b0; nbus.csr_wmask = '0; nbus.csr_wvalue = '0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_clear_race();
    test_masked();
    test_narrow();
    test_reset_midcount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/csr_timer_bank.md
# csr_timer_bank

Parametrised multi-channel timer block for the LoongArch CSR subsystem, generalising the single constant timer (TCFG/TVAL/TICLR) to NUM_TIMERS independent channels of configurable width, plus an optional 64-bit stable counter. It decodes its own CSR numbers from the shared CSR read/write port. It drives one registered interrupt-pending line per channel into the ESTAT interrupt-status logic.

## Interface
- NUM_TIMERS, 2, number of timer channels (1..4)
- TIMER_W, 32, counter width in bits (8..32)
- CSR_BASE, 14'h0041, CSR number of channel 0 TCFG; channel i occupies CSR_BASE+4i (TCFG), +4i+1 (TVAL), +4i+3 (TICLR)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- csr_num  in  14  CSR number for read and write
- csr_rvalue  out  32  combinational read data; 0 if csr_hit=0
- csr_hit  out  1  csr_num matches a register of this block
- csr_we  in  1  write enable
- csr_wmask  in  32  per-bit write mask
- csr_wvalue  in  32  write data
- timer_int  out  NUM_TIMERS  per-channel interrupt pending (registered)
- stable_cnt  out  64  stable counter value

## Operation
- Masked write rule for every field: new = wmask&wvalue | ~wmask&old; write takes effect at the edge where csr_we=1 and csr_num matches.
- TCFG(i): bit0 EN, bit1 PERIODIC, bits[TIMER_W-1:2] INITV. Bits 31:TIMER_W ignored on write, read as 0.
- TVAL(i): read-only, returns cnt(i) zero-extended; writes ignored.
- TICLR(i): reads 0. Write with wmask[0]&wvalue[0]=1 clears pending(i).
- Counter cnt(i), TIMER_W bits, priority per edge:
  - reset: cnt = all-ones.
  - TCFG(i) write whose post-mask EN=1: cnt = {post-mask INITV, 2'b00}.
  - EN=1 and cnt != all-ones: if cnt==0 and PERIODIC=1, cnt = {INITV,2'b00}; otherwise cnt = cnt-1. So a one-shot timer goes 0 -> all-ones, then stops.
  - else hold. TCFG write with EN=0 stops counting, cnt holds.
- Pending(i): set at the edge where EN=1 and cnt==0; cleared by TICLR(i) write; set wins if both occur in the same cycle. timer_int(i) = pending(i).
- Channels are fully independent; a write addresses at most one channel.
- Reset values: EN=0, PERIODIC=0, INITV=0, cnt=all-ones, pending=0, timer_int=0, stable_cnt=0. Reset mid-count aborts immediately; no interrupt is raised.

## Timing
- Reads are combinational: csr_rvalue reflects the current-cycle register state. There is no write-to-read bypass, so a read in the same cycle as a write returns the old value.
- TCFG write at edge k: cnt = INITV<<2 after edge k, first decrement at edge k+1.
- With load value L: cnt reaches 0 after edge k+L, timer_int rises after edge k+L+1.
- Periodic: reload at that same edge, so the interrupt period is L+1 cycles.
- TICLR write at edge m: timer_int low after edge m, unless a new set occurs at m.

## Configuration
- CSR_STABLE_CNT_EN defined: 64-bit counter, reset 0, increments by 1 every cycle, wraps 2^64-1 -> 0, drives stable_cnt.
- CSR_STABLE_CNT_EN undefined: counter not built, stable_cnt tied to 0.

## Test plan
- One-shot: TIMER_W=32. Write TCFG ch0 = 0x11 (INITV=4, EN=1). Required: TVAL reads 16, then decrements once per cycle to 0; timer_int[0]=1 one cycle after reaching 0; TVAL then reads 0xFFFFFFFF and holds.
- Periodic: write TCFG ch1 = 0x0B (INITV=2, PERIODIC, EN). Required: TVAL sequence 8..0, 8..0; timer_int[1] set every 9 cycles; ch0 unaffected.
- Clear race: hold pending, then write TICLR=1 in the cycle cnt==0 reappears. Required: timer_int stays 1. A TICLR write in any other cycle drops timer_int to 0.
- Masked write: TCFG=0x13, then write wvalue=0, wmask=0x1. Required: TCFG reads 0x12 and cnt freezes. Separately, a write with wmask=0 changes nothing.
- Narrow width: TIMER_W=16. Write TCFG=0xFFFF_0005. Required: TCFG reads 0x0005 and TVAL reads 0x0004 after load. One-shot wrap gives TVAL 0xFFFF.
- Reset and counter: assert reset mid-count. Required: all outputs 0 and TVAL=all-ones next cycle. With CSR_STABLE_CNT_EN, stable_cnt=N after N cycles out of reset; without it, stable_cnt stays 0.
